// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a 2-entry {pc,instr} FIFO.
// Optional FETCH_STATS_EN adds saturating stall_cycles / flush_count outputs.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 'h13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  instr_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    // state | meaning
    // IDLE  | no request outstanding; issues when the FIFO has room
    // WAIT  | one request outstanding, response will be pushed
    // DRAIN | one request outstanding but flushed; its response is dropped
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  started_q;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pc_inc;
    logic [DATA_WIDTH-1:0] pc_mem  [2];
    logic [DATA_WIDTH-1:0] ins_mem [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;
    logic                  push, pop, issue;
    logic                  unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign pc_inc         = fetch_pc_q + DATA_WIDTH'(4);

    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_valid ? ins_mem[rd_ptr_q] : NOP_INSTR;
    assign pc_out      = instr_valid ? pc_mem[rd_ptr_q]  : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        issue      = 1'b0;
        pop        = instr_valid && !stall && !redirect;
        case (state_q)
            IDLE: begin
                if (!redirect && started_q && count_q != 2'd2)
                    issue = 1'b1;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = pc_inc;
                        // back-to-back issue only if the pushed entry still leaves a free slot
                        if (count_q == 2'd0 || (count_q == 2'd1 && pop))
                            issue = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            if (state_q == WAIT && !imem_rvalid)
                state_d = DRAIN;
        end
        if (issue)
            state_d = WAIT;
    end

    assign imem_req  = issue;
    assign imem_addr = push ? pc_inc : fetch_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            if (redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (instr_valid && stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
